// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB endpoint FIFO bridge: IN-side FSM states,
// USB length field width and the default maximum IN packet size.
package usb_ep_pkg;

    localparam int unsigned USB_LEN_W       = 12;
    localparam int unsigned MAX_PKT_DEFAULT = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/usb_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry, and
// push/pop are each ignored when they would overflow or underflow.
module usb_sync_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem_q[rd_ptr_q];
        count   = count_q;
    end

    // Storage is deliberately left out of reset; only pointers and count clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usb_ep_fifo_bridge.sv
// Bridges one USB endpoint's IN/OUT byte streams to user valid/ready streams
// through two FIFOs, with an optional internal OUT->IN loopback.
module usb_ep_fifo_bridge
    import usb_ep_pkg::*;
#(
    parameter int unsigned EP_NUM   = 2,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned MAX_PKT  = MAX_PKT_DEFAULT,
    parameter int unsigned LOOPBACK = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           endpt,
    input  logic                 txact,
    input  logic                 txpop,
    output logic                 txval,
    output logic                 txcork,
    output logic [7:0]           txdat,
    output logic [USB_LEN_W-1:0] txdat_len,
    input  logic                 rxact,
    input  logic                 rxval,
    output logic                 rxrdy,
    input  logic [7:0]           rxdat,
    input  logic [7:0]           usr_tx_data,
    input  logic                 usr_tx_valid,
    output logic                 usr_tx_ready,
    output logic [7:0]           usr_rx_data,
    output logic                 usr_rx_valid,
    input  logic                 usr_rx_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam bit          LB = (LOOPBACK != 0);

    tx_state_e            state_q, state_d;
    logic [USB_LEN_W-1:0] len_q, len_d;
    logic [USB_LEN_W-1:0] sent_q, sent_d;

    logic          sel, tx_more, lb_move;
    logic          txf_push, txf_pop, txf_empty, txf_full;
    logic [7:0]    txf_wdata, txf_rdata;
    logic [CW-1:0] txf_count;
    logic          rxf_push, rxf_pop, rxf_empty, rxf_full;
    logic [7:0]    rxf_rdata;
    logic [CW-1:0] rxf_count;
    logic [31:0]   txf_count_w;

    usb_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_txf (
        .clk(clk), .rst(rst), .push(txf_push), .wdata(txf_wdata), .pop(txf_pop),
        .rdata(txf_rdata), .empty(txf_empty), .count(txf_count)
    );

    usb_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_rxf (
        .clk(clk), .rst(rst), .push(rxf_push), .wdata(rxdat), .pop(rxf_pop),
        .rdata(rxf_rdata), .empty(rxf_empty), .count(rxf_count)
    );

    always_comb begin
        sel      = (endpt == 4'(EP_NUM));
        txf_full = (txf_count == CW'(DEPTH));
        rxf_full = (rxf_count == CW'(DEPTH));
        tx_more  = (state_q == SEND) && (sent_q < len_q);
        lb_move  = LB && !rxf_empty && !txf_full;

        usr_tx_ready = !rst && !LB && !txf_full;
        usr_rx_valid = !rst && !LB && !rxf_empty;
        usr_rx_data  = LB ? '0 : rxf_rdata;
        txval        = !rst && tx_more;
        txcork       = rst || ((state_q == IDLE) && txf_empty);
        txdat        = txf_rdata;
        txdat_len    = len_q;
        rxrdy        = !rst && sel && rxact && !rxf_full;

        txf_push  = LB ? lb_move : (usr_tx_valid && usr_tx_ready);
        txf_wdata = LB ? rxf_rdata : usr_tx_data;
        txf_pop   = tx_more && txpop;
        rxf_push  = rxval && rxrdy;
        rxf_pop   = LB ? lb_move : (usr_rx_valid && usr_rx_ready);
    end

    // Packet length is frozen at IN start; later TXF writes wait for the next packet.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sent_d      = sent_q;
        txf_count_w = 32'(txf_count);
        case (state_q)
            IDLE: begin
                if (txact && sel) begin
                    state_d = SEND;
                    len_d   = (txf_count_w > MAX_PKT) ? USB_LEN_W'(MAX_PKT)
                                                      : USB_LEN_W'(txf_count_w);
                    sent_d  = '0;
                end
            end
            SEND: begin
                if (txf_pop) sent_d = sent_q + USB_LEN_W'(1);
                if (!txact || !sel) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
        end
    end

endmodule

// File: doc/usb_ep_fifo_bridge.md
USB_EP_FIFO_BRIDGE -- requirements
Module: usb_ep_fifo_bridge

Interface
REQ-001 SHALL have parameter EP_NUM, default 2: USB endpoint number served; other endpt values are ignored.
REQ-002 SHALL have parameter DEPTH, default 64: entries per FIFO; must be a power of 2, at least 4.
REQ-003 SHALL have parameter MAX_PKT, default 64: maximum IN packet length in bytes, at most 1024.
REQ-004 SHALL have parameter LOOPBACK, default 0: 1 routes OUT data to IN data internally; user ports are then idle.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port endpt, input, 4 bits: endpoint selected by the USB core.
REQ-008 SHALL have ports txact and txpop, inputs, 1 bit each: IN transaction active; byte consumed.
REQ-009 SHALL have ports txval and txcork, outputs, 1 bit each: txdat valid; no data (NAK).
REQ-010 SHALL have ports txdat (output, 8 bits: IN byte) and txdat_len (output, 12 bits: IN packet length).
REQ-011 SHALL have ports rxact and rxval (inputs, 1 bit each: OUT transaction active; rxdat valid) and rxrdy (output, 1 bit: byte accepted).
REQ-012 SHALL have port rxdat, input, 8 bits: OUT byte.
REQ-013 SHALL have ports usr_tx_data (input, 8), usr_tx_valid (input, 1) and usr_tx_ready (output, 1): user to host stream.
REQ-014 SHALL have ports usr_rx_data (output, 8), usr_rx_valid (output, 1) and usr_rx_ready (input, 1): host to user stream.

Function
REQ-015 SHALL contain two show-ahead FIFOs, TXF (user to host) and RXF (host to user), each with DEPTH entries, an occupancy count of $clog2(DEPTH)+1 bits, and wrapping pointers.
REQ-016 SHALL define sel as endpt==EP_NUM; txact and rxact with sel low SHALL have no effect.
REQ-017 SHALL write TXF when usr_tx_valid&&usr_tx_ready; usr_tx_ready SHALL equal !TXF.full, so a write to a full FIFO is never accepted, even during a same-cycle pop.
REQ-018 SHALL set usr_rx_data to the RXF head and usr_rx_valid to !RXF.empty, and SHALL pop RXF on usr_rx_valid&&usr_rx_ready.
REQ-019 SHALL run a tx FSM with states IDLE and SEND.
REQ-020 SHALL, in IDLE, move to SEND on txact&&sel, latching txdat_len=min(TXF.count,MAX_PKT) and clearing sent_cnt.
REQ-021 SHALL, in SEND, pop TXF and increment sent_cnt on txpop&&sent_cnt<txdat_len; a txpop at or beyond the length SHALL be ignored.
REQ-022 SHALL move from SEND to IDLE on !txact or on !sel; bytes not popped stay in TXF for the next packet.
REQ-023 SHALL set txdat to the TXF head and txval to (state==SEND)&&sent_cnt<txdat_len.
REQ-024 SHALL set txcork to TXF.empty in IDLE and hold it low in SEND, so an empty FIFO yields a NAK and never a zero-length packet.
REQ-025 SHALL set rxrdy to sel&&rxact&&!RXF.full, and SHALL push rxdat into RXF on rxval&&rxrdy.
REQ-026 SHALL support a simultaneous push and pop on either FIFO in one cycle: count unchanged, both operations done.
REQ-027 SHALL, with LOOPBACK=1, move data RXF->TXF one byte per cycle when !RXF.empty&&!TXF.full; usr_tx_ready, usr_rx_valid and usr_rx_data SHALL then be held 0.
REQ-028 SHALL limit latency as follows: a byte written to TXF appears at the TXF head, and counts toward txdat_len, on the next cycle; a byte pushed into RXF is visible on usr_rx_* on the next cycle.

Reset
REQ-029 SHALL, on rst, empty both FIFOs, set state=IDLE, txdat_len=0, sent_cnt=0, txval=0, txcork=1, rxrdy=0, usr_tx_ready=0 and usr_rx_valid=0; FIFO storage contents are not reset.
REQ-030 SHALL, on rst during SEND, abort the packet, discard all FIFO data, and return to IDLE on the next cycle.

Structure
REQ-031 SHALL place the state enum (IDLE, SEND), the USB length width (12) and the default MAX_PKT in package usb_ep_pkg.
REQ-032 SHALL implement the FIFO as one sub-module, usb_sync_fifo (params DEPTH, W=8), instantiated twice.

Verification
REQ-033 SHALL cover: write 10 bytes 0x00..0x09 to usr_tx, then txact with endpt=2 -> txdat_len=10, 10 txpops yield 0x00..0x09, and a 11th txpop is ignored.
REQ-034 SHALL cover: 100 bytes in TXF with MAX_PKT=64 -> first packet length 64, second packet length 36, then txcork=1.
REQ-035 SHALL cover: OUT burst of 70 bytes with DEPTH=64 and usr_rx_ready=0 -> rxrdy drops after 64 accepted, and those 64 bytes are read back in order.
REQ-036 SHALL cover: txact with endpt=3 -> no pops, txdat_len unchanged, and txcork reflects TXF.
REQ-037 SHALL cover: LOOPBACK=1 with 5 OUT bytes 0xA1..0xA5 -> the next IN packet has txdat_len=5 and data 0xA1..0xA5.
REQ-038 SHALL cover: rst asserted mid-SEND after 3 pops -> next cycle IDLE, txcork=1, TXF empty.
